// File: rtl/exa_vc_egress_mux.sv
// Egress stage merging vc_num exanet VC streams onto one link with packet-atomic round-robin.
// Optional per-VC packet counters are built when EXA_VC_EGRESS_STATS_EN is defined.
`timescale 1ns/1ps
module exa_vc_egress_mux #(
  parameter int vc_num = 4,
  localparam int vw = (vc_num > 1) ? $clog2(vc_num) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [vc_num-1:0]        exa_in_header_valid,
  output logic [vc_num-1:0]        exa_in_header_ready,
  input  logic [vc_num-1:0]        exa_in_payload_valid,
  output logic [vc_num-1:0]        exa_in_payload_ready,
  input  logic [vc_num-1:0]        exa_in_footer_valid,
  output logic [vc_num-1:0]        exa_in_footer_ready,
  input  logic [vc_num-1:0][127:0] exa_in_data,
  output logic                     exa_out_header_valid,
  input  logic                     exa_out_header_ready,
  output logic                     exa_out_payload_valid,
  input  logic                     exa_out_payload_ready,
  output logic                     exa_out_footer_valid,
  input  logic                     exa_out_footer_ready,
  output logic [127:0]             exa_out_data,
  output logic [vw-1:0]            o_grant_vc,
  output logic                     o_busy,
  output logic                     o_proto_err,
  output logic [vc_num-1:0][31:0]  o_pkt_cnt
);

  typedef enum logic {IDLE, PKT} state_t;
  typedef enum logic [1:0] {BT_HDR, BT_PAY, BT_FTR} beat_t;

  state_t        state;
  logic [vw-1:0] grant;
  logic [vw-1:0] rr;
  logic          hdr_done;
  logic [4:0]    rem;

  logic          vld_p1;
  beat_t         type_p1;
  logic [127:0]  data_p1;
  logic          proto_err_p1;

  logic          g_hv, g_pv, g_fv;
  logic [127:0]  g_data;
  logic          out_rdy_cur, can_load, in_pkt;
  logic          hdr_rdy, pay_rdy, ftr_rdy;
  logic          hdr_fire, pay_fire, ftr_fire, any_fire, out_fire;

  // Payload words implied by the header size field, capped at the 16-word maximum.
  function automatic logic [4:0] sat_rem(input logic [13:0] size);
    logic [13:0] words;
    if (size == 14'd0) return 5'd0;
    words = ((size - 14'd1) >> 4) + 14'd1;
    return (words > 14'd16) ? 5'd16 : words[4:0];
  endfunction

  function automatic logic [vw-1:0] rr_pick(input logic [vc_num-1:0] req, input logic [vw-1:0] ptr);
    logic [vw-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < vc_num; i++) begin
      idx = (int'(ptr) + i) % vc_num;
      if (!found && req[idx]) begin
        pick  = vw'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [vw-1:0] next_vc(input logic [vw-1:0] g);
    return (g == vw'(vc_num - 1)) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
    g_hv   = exa_in_header_valid[grant];
    g_pv   = exa_in_payload_valid[grant];
    g_fv   = exa_in_footer_valid[grant];
    g_data = exa_in_data[grant];
    case (type_p1)
      BT_HDR:  out_rdy_cur = exa_out_header_ready;
      BT_PAY:  out_rdy_cur = exa_out_payload_ready;
      BT_FTR:  out_rdy_cur = exa_out_footer_ready;
      default: out_rdy_cur = 1'b0;
    endcase
    can_load = !vld_p1 || out_rdy_cur;
    in_pkt   = (state == PKT);
    hdr_rdy  = in_pkt && !hdr_done && can_load;
    pay_rdy  = in_pkt && hdr_done && (rem != 5'd0) && can_load;
    // A pending payload beats an early footer while words are still owed.
    ftr_rdy  = in_pkt && hdr_done && can_load && ((rem == 5'd0) || !g_pv);
    hdr_fire = hdr_rdy && g_hv;
    pay_fire = pay_rdy && g_pv;
    ftr_fire = ftr_rdy && g_fv;
    any_fire = hdr_fire || pay_fire || ftr_fire;
    out_fire = vld_p1 && out_rdy_cur;
  end

  always_comb begin
    exa_in_header_ready         = '0;
    exa_in_payload_ready        = '0;
    exa_in_footer_ready         = '0;
    exa_in_header_ready[grant]  = hdr_rdy;
    exa_in_payload_ready[grant] = pay_rdy;
    exa_in_footer_ready[grant]  = ftr_rdy;
  end

  // Stage p0 -> p1: arbitration, length tracking and the one-entry output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      grant        <= '0;
      rr           <= '0;
      hdr_done     <= 1'b0;
      rem          <= 5'd0;
      vld_p1       <= 1'b0;
      type_p1      <= BT_HDR;
      data_p1      <= '0;
      proto_err_p1 <= 1'b0;
    end else begin
      proto_err_p1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|exa_in_header_valid) begin
            grant    <= rr_pick(exa_in_header_valid, rr);
            hdr_done <= 1'b0;
            state    <= PKT;
          end
        end
        PKT: begin
          if (hdr_fire) begin
            hdr_done <= 1'b1;
            rem      <= sat_rem(g_data[61:48]);
          end
          if (pay_fire) rem <= rem - 5'd1;
          if (ftr_fire) begin
            proto_err_p1 <= (rem != 5'd0);
            rem          <= 5'd0;
            hdr_done     <= 1'b0;
            rr           <= next_vc(grant);
            state        <= IDLE;
          end
        end
      endcase
      if (any_fire) begin
        vld_p1  <= 1'b1;
        type_p1 <= hdr_fire ? BT_HDR : (pay_fire ? BT_PAY : BT_FTR);
        data_p1 <= g_data;
      end else if (out_fire) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign exa_out_header_valid  = vld_p1 && (type_p1 == BT_HDR);
  assign exa_out_payload_valid = vld_p1 && (type_p1 == BT_PAY);
  assign exa_out_footer_valid  = vld_p1 && (type_p1 == BT_FTR);
  assign exa_out_data          = data_p1;
  assign o_grant_vc            = grant;
  assign o_busy                = (state == PKT);
  assign o_proto_err           = proto_err_p1;

`ifdef EXA_VC_EGRESS_STATS_EN
  logic [vw-1:0]             vc_p1;
  logic [vc_num-1:0][31:0]   pkt_cnt;

  // Stage p1 -> stats: the held beat remembers its source VC so counts follow the output footer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vc_p1   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (any_fire) vc_p1 <= grant;
      if (out_fire && (type_p1 == BT_FTR)) pkt_cnt[vc_p1] <= pkt_cnt[vc_p1] + 32'd1;
    end
  end

  assign o_pkt_cnt = pkt_cnt;
`else
  assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_exa_vc_egress_mux.sv
// Scoreboard bench for exa_vc_egress_mux: per-VC beat sources, negedge output monitor.
`timescale 1ns/1ps
module tb_exa_vc_egress_mux;
  localparam int VCN   = 4;
  localparam int DEPTH = 64;
  localparam logic [1:0] T_HDR = 2'd0, T_PAY = 2'd1, T_FTR = 2'd2;

  typedef struct packed { logic [1:0] typ; logic [127:0] data; } beat_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [VCN-1:0] in_hv = '0, in_pv = '0, in_fv = '0;
  logic [VCN-1:0] in_hr, in_pr, in_fr;
  logic [VCN-1:0][127:0] in_data = '0;
  logic out_hv, out_pv, out_fv;
  logic out_rdy = 1'b1;
  logic [127:0] out_data;
  logic [1:0] grant_vc;
  logic busy, proto_err;
  logic [VCN-1:0][31:0] pkt_cnt;

  exa_vc_egress_mux #(.vc_num(VCN)) dut (
    .clk(clk), .resetn(resetn),
    .exa_in_header_valid(in_hv), .exa_in_header_ready(in_hr),
    .exa_in_payload_valid(in_pv), .exa_in_payload_ready(in_pr),
    .exa_in_footer_valid(in_fv), .exa_in_footer_ready(in_fr),
    .exa_in_data(in_data),
    .exa_out_header_valid(out_hv), .exa_out_header_ready(out_rdy),
    .exa_out_payload_valid(out_pv), .exa_out_payload_ready(out_rdy),
    .exa_out_footer_valid(out_fv), .exa_out_footer_ready(out_rdy),
    .exa_out_data(out_data),
    .o_grant_vc(grant_vc), .o_busy(busy), .o_proto_err(proto_err),
    .o_pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  beat_t src_mem [VCN][DEPTH];
  int    src_rd [VCN];
  int    src_wr [VCN];
  int    flush_gen = 0;
  beat_t exp_q[$];
  int    grant_log[$];
  int    gap_log[$];
  int    checks = 0;
  int    errors = 0;
  logic  bp_mode = 1'b0;
  int    pr_seen = 0;
  int    proto_cycles = 0;
  int    beats_out = 0;
  time   hdr_fire_t = 0;
  time   out_hdr_t = 0;

  // Sources: present the head beat of each VC at negedge, retire it on a handshake.
  initial begin : driver
    logic [VCN-1:0] fired;
    beat_t b;
    int seen_gen;
    seen_gen = 0;
    for (int v = 0; v < VCN; v++) src_rd[v] = 0;
    forever begin
      @(negedge clk);
      if (seen_gen != flush_gen) begin
        for (int v = 0; v < VCN; v++) src_rd[v] = src_wr[v];
        seen_gen = flush_gen;
      end
      for (int v = 0; v < VCN; v++) begin
        in_hv[v] = 1'b0; in_pv[v] = 1'b0; in_fv[v] = 1'b0; in_data[v] = '0;
        if (src_rd[v] < src_wr[v]) begin
          b = src_mem[v][src_rd[v]];
          in_data[v] = b.data;
          case (b.typ)
            T_HDR:   in_hv[v] = 1'b1;
            T_PAY:   in_pv[v] = 1'b1;
            default: in_fv[v] = 1'b1;
          endcase
        end
      end
      #4;
      fired = (in_hv & in_hr) | (in_pv & in_pr) | (in_fv & in_fr);
      if (|in_pr) pr_seen++;
      @(posedge clk);
      for (int v = 0; v < VCN; v++) begin
        if (fired[v]) begin
          if (in_hv[v]) hdr_fire_t = $time;
          src_rd[v]++;
        end
      end
    end
  end

  initial begin : sink
    forever begin
      @(posedge clk);
      #1;
      out_rdy = bp_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on each output handshake.
  initial begin : monitor
    beat_t got, exp, stall_b;
    logic  stall_q, busy_q, hv_q;
    int    nv, idle_run;
    stall_q = 1'b0; busy_q = 1'b0; hv_q = 1'b0; idle_run = 0; stall_b = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        stall_q = 1'b0; busy_q = 1'b0; hv_q = 1'b0; idle_run = 0;
      end else begin
        nv = int'(out_hv) + int'(out_pv) + int'(out_fv);
        got.typ  = out_fv ? T_FTR : (out_pv ? T_PAY : T_HDR);
        got.data = out_data;
        if (nv > 1) begin
          checks++; errors++;
          $display("FAIL out_onehot got=%0d valids required<=1", nv);
        end
        if (stall_q) begin
          checks++;
          if (nv == 0 || got !== stall_b) begin
            errors++;
            $display("FAIL stall_stable got=%0d/%h required=%0d/%h", got.typ, got.data, stall_b.typ, stall_b.data);
          end
        end
        stall_q = 1'b0;
        if (nv != 0 && out_rdy) begin
          beats_out++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat got=%0d/%h required=none", got.typ, got.data);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL beat got=%0d/%h required=%0d/%h", got.typ, got.data, exp.typ, exp.data);
            end
          end
        end else if (nv != 0) begin
          stall_q = 1'b1;
          stall_b = got;
        end
        if (out_hv && !hv_q) out_hdr_t = $time;
        hv_q = out_hv;
        if (proto_err) proto_cycles++;
        if (busy && !busy_q) begin
          grant_log.push_back(int'(grant_vc));
          if (grant_log.size() > 1) gap_log.push_back(idle_run);
          idle_run = 0;
        end else if (!busy) begin
          idle_run++;
        end
        busy_q = busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic push(input int vc, input beat_t b);
    src_mem[vc][src_wr[vc]] = b;
    src_wr[vc]++;
    exp_q.push_back(b);
  endtask

  task automatic enq(input int vc, input logic [13:0] size, input int npay, input logic [31:0] tag);
    beat_t b;
    b.typ = T_HDR;
    b.data = {tag, 32'h4844_5200, 2'b00, size, 48'h0000_5AA5_0000 ^ {16'h0, tag}};
    push(vc, b);
    for (int i = 0; i < npay; i++) begin
      b.typ = T_PAY;
      b.data = {tag, 32'h5041_5900 + 32'(i), 32'hDEAD_BEEF ^ tag, 32'(i)};
      push(vc, b);
    end
    b.typ = T_FTR;
    b.data = {tag, 32'h4654_5200, ~tag, 32'h0};
    push(vc, b);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    logic done;
    n = 0; done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (exp_q.size() == 0) && !busy;
      for (int v = 0; v < VCN; v++) if (src_rd[v] != src_wr[v]) done = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain got=%0d cycles required<%0d", name, n, budget);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valids"}, {out_hv, out_pv, out_fv}, 3'b000);
    chk({tag, "_out_data"}, out_data, 128'h0);
    chk({tag, "_in_readies"}, {in_hr, in_pr, in_fr}, 12'h000);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_grant"}, grant_vc, 2'd0);
    chk({tag, "_proto_err"}, proto_err, 1'b0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 128'h0);
  endtask

  initial begin : main
    int rr_order [5] = '{0, 1, 2, 3, 0};
    int g0, p0, b0, s0, base, n;
    for (int v = 0; v < VCN; v++) src_wr[v] = 0;

    repeat (3) tick();
    chk_reset_vals("rst");

    // Round-robin: every VC requesting from the moment reset releases.
    resetn = 1'b1;
    g0 = grant_log.size();
    enq(0, 14'h0, 0, 32'h0000_0100);
    enq(1, 14'h0, 0, 32'h0000_0101);
    enq(2, 14'h0, 0, 32'h0000_0102);
    enq(3, 14'h0, 0, 32'h0000_0103);
    enq(0, 14'h0, 0, 32'h0000_0104);
    wait_done("rr", 200);
    chk("rr_grant_count", grant_log.size() - g0, 5);
    for (int i = 0; i < 5; i++)
      if (g0 + i < grant_log.size()) chk($sformatf("rr_grant%0d", i), grant_log[g0 + i], rr_order[i]);
    chk("rr_gap_count", gap_log.size(), 4);
    for (int i = 0; i < gap_log.size(); i++) chk($sformatf("rr_idle_gap%0d", i), gap_log[i], 1);

    // Single packet on VC2, two payload words.
    p0 = proto_cycles;
    g0 = grant_log.size();
    enq(2, 14'h20, 2, 32'h0000_0200);
    wait_done("single", 100);
    chk("single_grant_count", grant_log.size() - g0, 1);
    if (g0 < grant_log.size()) chk("single_grant_vc", grant_log[g0], 2);
    chk("single_hdr_latency", 128'(out_hdr_t - hdr_fire_t), 5);
    chk("single_busy_low", busy, 1'b0);
`ifdef EXA_VC_EGRESS_STATS_EN
    chk("single_pkt_cnt2", pkt_cnt[2], 32'd1);
    chk("single_pkt_cnt0", pkt_cnt[0], 32'd2);
`else
    chk("single_pkt_cnt_tied", pkt_cnt, 128'h0);
`endif

    // Sixteen payload words under random output backpressure.
    b0 = beats_out;
    bp_mode = 1'b1;
    enq(1, 14'h100, 16, 32'h0000_0300);
    wait_done("backpressure", 600);
    bp_mode = 1'b0;
    chk("bp_beats_out", beats_out - b0, 18);
    chk("no_proto_err_so_far", proto_cycles - p0, 0);

    // Early footer: three words announced, one sent.
    p0 = proto_cycles;
    enq(3, 14'h30, 1, 32'h0000_0400);
    wait_done("early_ftr", 100);
    chk("early_ftr_proto_cycles", proto_cycles - p0, 1);
    chk("early_ftr_idle", busy, 1'b0);

    // Zero-size packet: header straight to footer.
    s0 = pr_seen;
    p0 = proto_cycles;
    enq(1, 14'h0, 0, 32'h0000_0500);
    wait_done("zero_size", 100);
    chk("zero_size_no_payload_ready", pr_seen - s0, 0);
    chk("zero_size_no_proto_err", proto_cycles - p0, 0);

    // Reset in the middle of a 16-word packet.
    base = src_rd[3];
    enq(3, 14'h100, 16, 32'h0000_0600);
    n = 0;
    while (src_rd[3] < base + 6 && n < 200) begin
      tick();
      n++;
    end
    chk("midrst_reached_5_payloads", src_rd[3] >= base + 6, 1'b1);
    resetn = 1'b0;
    flush_gen++;
    #1;
    chk_reset_vals("midrst");
    repeat (2) tick();
    resetn = 1'b1;
    g0 = grant_log.size();
    enq(0, 14'h10, 1, 32'h0000_0700);
    enq(2, 14'h0, 0, 32'h0000_0701);
    wait_done("post_rst", 100);
    chk("post_rst_grant_count", grant_log.size() - g0, 2);
    if (g0 + 1 < grant_log.size()) begin
      chk("post_rst_grant_first", grant_log[g0], 0);
      chk("post_rst_grant_second", grant_log[g0 + 1], 2);
    end
`ifdef EXA_VC_EGRESS_STATS_EN
    chk("post_rst_pkt_cnt0", pkt_cnt[0], 32'd1);
    chk("post_rst_pkt_cnt3", pkt_cnt[3], 32'd0);
`else
    chk("post_rst_pkt_cnt_tied", pkt_cnt, 128'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exa_vc_egress_mux.md
# exa_vc_egress_mux

Per-output-port egress stage of the virtual-channel crossbar. It merges `vc_num` per-VC exanet packet streams into the single exanet link that leaves the switch, which feeds the port's traffic consumer or the next hop. Arbitration is packet-atomic round-robin: a granted VC keeps the link from header to footer. A one-entry output register and a payload-length checker provide registered outputs and protocol sanity.

## Interface
- `vc_num`, 4, number of virtual channels (2..8); VC index width `vw = $clog2(vc_num)`.
- `clk`  in  1  sole clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `exa_in[vc_num]`  exanet.slave  —  per-VC input: header/payload/footer valid/ready, `data[127:0]`.
- `exa_out`  exanet.master  —  merged output link, same signal set.
- `o_grant_vc`  out  vw  VC currently owning the link; valid while `o_busy`.
- `o_busy`  out  1  a packet is in progress.
- `o_proto_err`  out  1  one-cycle pulse on a payload-length violation.
- `o_pkt_cnt[vc_num]`  out  32 each  per-VC forwarded-packet count (see Configuration).

## Operation
- States: IDLE, PKT.
- IDLE: all input readies low. If any `exa_in[v].header_valid` is high, grant the first requesting VC at or after the round-robin pointer `rr` (modulo `vc_num`). Register the grant, set `o_busy`, go to PKT. No request: stay in IDLE.
- PKT: only the granted VC's beats are routed to the output register. Beat order is header, payload ×N, footer.
  - On header handshake, load `rem = (hdr[61:48]==0) ? 0 : ((hdr[61:48]-1)>>4)+1`. `rem` is 5 bits, max 16.
  - While `rem>0`, payload beats are accepted and `rem` decrements on each.
  - Footer is accepted when `rem==0`. If footer_valid arrives with `rem>0`, the footer is still accepted and forwarded, and `o_proto_err` pulses.
  - A payload_valid with `rem==0` is not accepted (payload_ready stays low) until the footer arrives.
  - If payload_valid and footer_valid are both high with `rem>0`, the payload wins.
- Footer handshake on the input side: `rr <= grant+1` (wraps), go to IDLE, drop `o_busy`.
- Output register: holds one beat (data plus beat type). Input ready for the granted VC's expected beat is `!out_valid | out_ready`. Exactly one of header/payload/footer valid is high on `exa_out` at any time.
- Non-granted VCs see all readies low.

## Timing
- Reset values: all `exa_out` valids 0, `exa_out.data` 0, all `exa_in` readies 0, `o_busy` 0, `o_grant_vc` 0, `o_proto_err` 0, `rr` 0, `rem` 0, `o_pkt_cnt` 0, state IDLE.
- Latency: input beat to `exa_out` is 1 cycle. The arbitration bubble is 1 cycle (header_valid in IDLE; header_ready no earlier than the next cycle).
- Back-to-back packets: the footer accept cycle is followed by one IDLE cycle, so a 0-payload packet takes at least 3 input cycles.
- A held output beat keeps data and valid stable until `out_ready`. Throughput with continuous ready is one beat per cycle inside a packet.
- Footer handshake and a new header request in the same cycle: the new header is arbitrated in the following IDLE cycle using the updated `rr`.
- Reset asserted mid-packet: everything returns to reset values immediately (asynchronously). The partial packet is abandoned, and the downstream sees valids drop without a footer.

## Configuration
- `EXA_VC_EGRESS_STATS_EN` defined: `o_pkt_cnt[v]` increments by 1 on each footer handshake on `exa_out` whose packet came from VC v. The counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Not defined: the counters are not built and `o_pkt_cnt[*]` is tied to 0. All other behaviour is identical.

## Test plan
- Single packet: VC2 sends a header with size field 0x20 (2 payload words) and `out_ready`=1. Required:
  - `o_grant_vc`=2.
  - `exa_out` shows the header 1 cycle after header_ready, then 2 payloads, then the footer, with data bit-identical.
  - `o_busy` falls after the footer; `o_pkt_cnt[2]`=1 when stats are enabled.
- Round-robin: all 4 VCs hold 0-payload packets continuously from reset. Required: grant order 0,1,2,3,0 and exactly one IDLE cycle between packets.
- Backpressure: size 0x100 (16 payloads) with `out_ready` toggling pseudo-randomly at 50%. Required: 18 beats out, in order, none duplicated or lost, data stable while stalled.
- Early footer: size 0x30 (3 payloads), but the source sends 1 payload then footer. Required: footer forwarded, `o_proto_err` high for exactly 1 cycle, FSM back in IDLE.
- Zero-size packet: size 0. Required: payload_ready never asserted; header then footer on `exa_out`.
- Reset mid-packet: assert `resetn`=0 after 5 payload beats of a 16-payload packet. Required:
  - All outputs at reset values in the same cycle.
  - After release, a fresh VC0 packet is forwarded correctly with `rr` starting at 0.
